// File: rtl/fpu_seq_ctrl_pkg.sv
// Opcode, state and latency helpers shared by the FP sequencer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package fpu_pkg;

   typedef enum logic [3:0] {
      FADD = 4'd0,
      FSUB = 4'd1,
      FMUL = 4'd2,
      FDIV = 4'd3,
      FABS = 4'd4,
      FNEG = 4'd5
   } fpu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      WB   = 2'd2
   } state_t;

   // Only the six defined opcodes may start the FP unit.
   function automatic logic op_legal(input logic [3:0] op);
      return (op <= 4'd5);
   endfunction

   // Cycles spent in BUSY for a given opcode. Returned as a plain integer;
   // the caller narrows it to its own counter width.
   function automatic int lat_of(input logic [3:0] op, input int add_lat,
                                 input int mul_lat, input int div_lat);
      case (op)
         FADD, FSUB: lat_of = add_lat;
         FMUL:       lat_of = mul_lat;
         FDIV:       lat_of = div_lat;
         default:    lat_of = 1;
      endcase
   endfunction

endpackage

// File: rtl/fpu_seq_ctrl_lat_cnt.sv
// Loadable down-counter timing the FP unit's per-op latency.
// Latency: load/clear take effect at the next edge; is_one is combinational from the count.
// Backpressure: none; clear beats load beats decrement, decrement saturates at zero.
module fpu_lat_cnt #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic [CNT_W-1:0] value,
   output logic             is_one
);

   // Count register: flush clears, an accepted issue loads, BUSY decrements.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         value <= '0;
      end else if (clr) begin
         value <= '0;
      end else if (load) begin
         value <= load_val;
      end else if (dec && (value != '0)) begin
         value <= value - CNT_W'(1);
      end
   end

   assign is_one = (value == CNT_W'(1));

endmodule

// File: rtl/fpu_seq_ctrl.sv
// Sequences one FP op at a time into the fixed-latency FP unit and strobes writeback.
// Latency: issue-to-writeback is L+1 cycles (L = per-op latency); fpu_start the cycle after accept.
// Backpressure: stall holds decode while BUSY with a new issue pending, or on a RAW hit against pend_fd.
module fpu_seq_ctrl #(
   parameter int ADD_LAT = 2,
   parameter int MUL_LAT = 3,
   parameter int DIV_LAT = 8,
   parameter int CNT_W   = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       issue_valid,
   input  logic [3:0] issue_op,
   input  logic [4:0] issue_fd,
   input  logic       dec_fp_use,
   input  logic [4:0] dec_fs,
   input  logic [4:0] dec_ft,
   input  logic       flush,
   output logic       fpu_start,
   output logic [3:0] fpu_op,
   output logic       wb_valid,
   output logic [4:0] wb_fd,
   output logic       busy,
   output logic       stall,
   output logic       op_err
);
   import fpu_pkg::*;

   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_BUSY = BUSY;
   localparam logic [1:0] S_WB   = WB;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [4:0]       pend_fd;
   logic [CNT_W-1:0] cnt_val;
   logic [CNT_W-1:0] cnt_load_val;
   logic             cnt_one;
   logic             in_busy;
   logic             in_wb;
   logic             legal;
   logic             structural;
   logic             raw;
   logic             accept;
   logic             bad_issue;

   assign in_busy = (state == S_BUSY);
   assign in_wb   = (state == S_WB);
   assign legal   = op_legal(issue_op);

   // A new issue cannot enter while the FP unit is occupied.
   assign structural = issue_valid & in_busy;
   // The register file write is not bypassed, so readers of pend_fd wait through WB too.
   assign raw = dec_fp_use & (state != S_IDLE) &
                ((dec_fs == pend_fd) | (dec_ft == pend_fd));
   assign stall = ~flush & (structural | raw);

   assign accept    = issue_valid & ~stall & ~flush & legal & ~in_busy;
   assign bad_issue = issue_valid & ~stall & ~flush & ~legal;

   assign cnt_load_val = CNT_W'(lat_of(issue_op, ADD_LAT, MUL_LAT, DIV_LAT));

   fpu_lat_cnt #(
      .CNT_W(CNT_W)
   ) u_lat_cnt (
      .clk      (clk),
      .reset_n  (reset_n),
      .clr      (flush),
      .load     (accept),
      .load_val (cnt_load_val),
      .dec      (in_busy),
      .value    (cnt_val),
      .is_one   (cnt_one)
   );

   // Next-state: flush always wins; WB can chain straight into the next op.
   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: if (accept) state_nxt = S_BUSY;
            // A zero count only arises from a zero-latency parameter; leave rather than hang.
            S_BUSY: if (cnt_one || (cnt_val == '0)) state_nxt = S_WB;
            S_WB:   state_nxt = accept ? S_BUSY : S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // State, scoreboard destination, held opcode and the two registered pulses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         pend_fd   <= '0;
         fpu_op    <= '0;
         fpu_start <= 1'b0;
         op_err    <= 1'b0;
      end else begin
         state     <= state_nxt;
         fpu_start <= accept;
         op_err    <= bad_issue;
         if (accept) begin
            pend_fd <= issue_fd;
            fpu_op  <= issue_op;
         end
      end
   end

   assign busy     = in_busy;
   assign wb_valid = in_wb;
   assign wb_fd    = in_wb ? pend_fd : 5'd0;

endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// Directed plus random bench for fpu_seq_ctrl against a timeline reference model.
// Latency: model predicts every output per cycle from the accept cycle and op latency.
// Backpressure: stall expectations derived from the pending op's BUSY/WB window.
module tb_fpu_seq_ctrl;

   localparam int ADD_LAT = 2;
   localparam int MUL_LAT = 3;
   localparam int DIV_LAT = 8;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       issue_valid;
   logic [3:0] issue_op;
   logic [4:0] issue_fd;
   logic       dec_fp_use;
   logic [4:0] dec_fs;
   logic [4:0] dec_ft;
   logic       flush;
   logic       fpu_start;
   logic [3:0] fpu_op;
   logic       wb_valid;
   logic [4:0] wb_fd;
   logic       busy;
   logic       stall;
   logic       op_err;

   fpu_seq_ctrl #(
      .ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)
   ) dut (
      .clk(clk), .reset_n(reset_n), .issue_valid(issue_valid), .issue_op(issue_op),
      .issue_fd(issue_fd), .dec_fp_use(dec_fp_use), .dec_fs(dec_fs), .dec_ft(dec_ft),
      .flush(flush), .fpu_start(fpu_start), .fpu_op(fpu_op), .wb_valid(wb_valid),
      .wb_fd(wb_fd), .busy(busy), .stall(stall), .op_err(op_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;

   // Reference model: the one pending op as (accept cycle, latency, fd).
   bit p_vld = 0;
   int p_a = 0;
   int p_l = 0;
   int p_fd = 0;
   int exp_op = 0;
   int err_cyc = -1;

   // Observation counters for the directed checks.
   int last_wb_cyc = -1;
   int last_wb_fd = -1;
   int wb_cnt = 0;
   int stall_cnt = 0;
   int start_cnt = 0;
   int err_cnt = 0;

   function automatic int lat(input int op);
      if (op <= 1) return ADD_LAT;
      if (op == 2) return MUL_LAT;
      if (op == 3) return DIV_LAT;
      return 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic step(input bit rst, input bit iv, input int op, input int fd,
                       input bit use_fp, input int fs, input int ft, input bit fl);
      bit e_busy, e_wb, e_start, e_stall, e_err;
      int e_wbfd;
      int t;
      reset_n     = rst;
      issue_valid = iv;
      issue_op    = 4'(op);
      issue_fd    = 5'(fd);
      dec_fp_use  = use_fp;
      dec_fs      = 5'(fs);
      dec_ft      = 5'(ft);
      flush       = fl;
      t = cyc;
      if (!rst) begin
         p_vld = 0; exp_op = 0; err_cyc = -1;
      end
      e_busy  = p_vld && (t >= p_a + 1) && (t <= p_a + p_l);
      e_wb    = p_vld && (t == p_a + p_l + 1);
      e_start = p_vld && (t == p_a + 1);
      e_stall = !fl && ((iv && e_busy) ||
                        (use_fp && (e_busy || e_wb) && (fs == p_fd || ft == p_fd)));
      e_err   = (err_cyc == t);
      e_wbfd  = e_wb ? p_fd : 0;

      @(negedge clk);
      chk("stall",     32'(stall),     32'(e_stall));
      chk("fpu_start", 32'(fpu_start), 32'(e_start));
      chk("busy",      32'(busy),      32'(e_busy));
      chk("wb_valid",  32'(wb_valid),  32'(e_wb));
      chk("wb_fd",     32'(wb_fd),     32'(e_wbfd));
      chk("fpu_op",    32'(fpu_op),    32'(exp_op));
      chk("op_err",    32'(op_err),    32'(e_err));

      if (wb_valid === 1'b1) begin
         last_wb_cyc = t; last_wb_fd = int'(wb_fd); wb_cnt++;
      end
      if (stall === 1'b1) stall_cnt++;
      if (fpu_start === 1'b1) start_cnt++;
      if (op_err === 1'b1) err_cnt++;

      if (rst) begin
         if (p_vld && t >= p_a + p_l + 1) p_vld = 0;
         if (fl) begin
            p_vld = 0;
         end else if (iv && !e_stall && !e_busy) begin
            if (op <= 5) begin
               p_vld = 1; p_a = t; p_l = lat(op); p_fd = fd; exp_op = op;
            end else begin
               err_cyc = t + 1;
            end
         end
      end

      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int c0;
      reset_n = 1'b0; issue_valid = 1'b0; issue_op = '0; issue_fd = '0;
      dec_fp_use = 1'b0; dec_fs = '0; dec_ft = '0; flush = 1'b0;
      @(posedge clk);
      #1;

      // Reset state, with inputs wiggling.
      step(0, 1, 0, 3, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      idle(2);

      // FADD fd=3: writeback exactly three cycles after the issue cycle.
      c0 = cyc; start_cnt = 0;
      step(1, 1, 0, 3, 0, 0, 0, 0);
      idle(5);
      chk("fadd_wb_lat", 32'(last_wb_cyc - c0), 32'd3);
      chk("fadd_wb_fd", 32'(last_wb_fd), 32'd3);
      chk("fadd_starts", 32'(start_cnt), 32'd1);

      // FDIV fd=7, then FMUL fd=9 held from cycle 2: accepted in WB, written back at 13.
      c0 = cyc;
      step(1, 1, 3, 7, 0, 0, 0, 0);
      idle(1);
      stall_cnt = 0;
      for (int k = 2; k <= 9; k++) step(1, 1, 2, 9, 0, 0, 0, 0);
      chk("fdiv_struct_stalls", 32'(stall_cnt), 32'd7);
      idle(6);
      chk("b2b_fmul_wb_lat", 32'(last_wb_cyc - c0), 32'd13);
      chk("b2b_fmul_wb_fd", 32'(last_wb_fd), 32'd9);

      // FMUL fd=5 with a reader of f5 in decode: stalled through WB only.
      step(1, 1, 2, 5, 0, 0, 0, 0);
      stall_cnt = 0;
      for (int k = 1; k <= 5; k++) step(1, 0, 0, 0, 1, 0, 5, 0);
      chk("raw_stalls", 32'(stall_cnt), 32'd4);
      step(1, 1, 2, 5, 0, 0, 0, 0);
      stall_cnt = 0;
      for (int k = 1; k <= 5; k++) step(1, 0, 0, 0, 1, 6, 6, 0);
      chk("no_raw_stalls", 32'(stall_cnt), 32'd0);

      // FDIV fd=2 killed by flush in cycle 4; the concurrent FADD is dropped.
      c0 = cyc; wb_cnt = 0; start_cnt = 0;
      step(1, 1, 3, 2, 0, 0, 0, 0);
      idle(3);
      step(1, 1, 0, 4, 0, 0, 0, 1);
      chk("flush_busy_c5", 32'(busy), 32'd0);
      idle(12);
      chk("flush_no_wb", 32'(wb_cnt), 32'd0);
      chk("flush_one_start", 32'(start_cnt), 32'd1);

      // Illegal opcode, then FABS straight after.
      c0 = cyc; start_cnt = 0; err_cnt = 0;
      step(1, 1, 9, 1, 0, 0, 0, 0);
      step(1, 1, 4, 1, 0, 0, 0, 0);
      idle(4);
      chk("illegal_err_cnt", 32'(err_cnt), 32'd1);
      chk("fabs_wb_lat", 32'(last_wb_cyc - (c0 + 1)), 32'd2);
      chk("fabs_one_start", 32'(start_cnt), 32'd1);

      // Reset mid-FDIV in cycles 4-5, then a clean FADD.
      c0 = cyc; wb_cnt = 0;
      step(1, 1, 3, 7, 0, 0, 0, 0);
      idle(3);
      step(0, 1, 0, 7, 1, 7, 7, 0);
      step(0, 1, 0, 7, 1, 7, 7, 0);
      step(1, 1, 0, 3, 0, 0, 0, 0);
      idle(5);
      chk("rst_fadd_wb_lat", 32'(last_wb_cyc - (c0 + 6)), 32'd3);
      chk("rst_wb_cnt", 32'(wb_cnt), 32'd1);

      // Random traffic with a narrow register range so RAW hits are frequent.
      for (int i = 0; i < 600; i++) begin
         bit r_rst, r_iv, r_use, r_fl;
         int r_op;
         r_rst = ($urandom_range(0, 99) != 0);
         r_iv  = ($urandom_range(0, 1) == 1);
         r_use = ($urandom_range(0, 9) < 3);
         r_fl  = ($urandom_range(0, 19) == 0);
         r_op  = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 5))
                                             : int'($urandom_range(6, 15));
         step(r_rst, r_iv, r_op, int'($urandom_range(0, 3)), r_use,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), r_fl);
      end
      idle(12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
